pu_riscv_memrsp: RTL and testbench

Memory-side responder paired with the CPU-side memory access buffer. It accepts that buffer's req/ack requests, forwards them to a split-transaction memory port, and tracks outstanding transactions. Returned data is collected in order in a DEPTH-entry response queue and delivered to the CPU pipeline with valid/ready. It also flushes pending responses on clr_i, so stale data from killed accesses never reaches the pipeline.

---
 rtl/pu_riscv_memrsp_pkg.sv | 13 +
 rtl/pu_riscv_memrsp_fifo.sv | 58 +++++
 rtl/pu_riscv_memrsp.sv | 87 ++++++++
 tb/tb_pu_riscv_memrsp.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pu_riscv_memrsp_pkg.sv
// Shared definitions for the memory-side responder: default sizing and the
// occupancy-counter width helper.
package pu_riscv_memrsp_pkg;

  localparam int unsigned DEF_DEPTH = 2;
  localparam int unsigned DEF_DBITS = 64;

  // Counters must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pu_riscv_memrsp_fifo.sv
// In-order response queue: DEPTH entries with wrapping pointers and an occupancy
// count; the head output holds its last value while the queue is empty.
module pu_riscv_memrsp_fifo
  import pu_riscv_memrsp_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned DBITS = DEF_DBITS,
  parameter int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [DBITS-1:0] d_i,
  input  logic             re_i,
  output logic [DBITS-1:0] q_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DBITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic [DBITS-1:0] last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      last_q <= '0;
    end else if (clr_i) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      last_q <= q_o;
    end else begin
      if (we_i) begin
        assert (count != CNT_W'(DEPTH)) else $error("response queue overflow");
        wptr <= wptr + PTR_W'(1);
      end
      if (re_i) rptr <= rptr + PTR_W'(1);
      count  <= count + CNT_W'(we_i) - CNT_W'(re_i);
      last_q <= q_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i && !clr_i) mem[wptr] <= d_i;
  end

  // last_q keeps the most recently presented head so the output is stable when empty.
  assign q_o     = (count != '0) ? mem[rptr] : last_q;
  assign count_o = count;

endmodule

// File: rtl/pu_riscv_memrsp.sv
// Memory-side responder: forwards accepted requests to a split-transaction port,
// tracks credit, queues responses in order and discards responses killed by clr_i.
module pu_riscv_memrsp
  import pu_riscv_memrsp_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned DBITS = DEF_DBITS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             ena_i,
  input  logic             req_i,
  input  logic [DBITS-1:0] d_i,
  output logic             ack_o,
  output logic             mem_req_o,
  output logic [DBITS-1:0] mem_d_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic [DBITS-1:0] mem_q_i,
  output logic             rsp_valid_o,
  output logic [DBITS-1:0] rsp_q_o,
  input  logic             rsp_ready_i,
  output logic             empty_o,
  output logic             full_o,
  output logic             err_o
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] drop;
  logic [CNT_W:0]   used;
  logic             credit;
  logic             beat;
  logic             we;
  logic             re;
  logic             err;

  always_comb begin
    used      = {1'b0, inflight} + {1'b0, count};
    credit    = used < (CNT_W+1)'(DEPTH);
    mem_req_o = req_i & ena_i & ~clr_i & credit;
    ack_o     = mem_req_o & mem_gnt_i;
    mem_d_o   = d_i;
    beat      = mem_rvalid_i & (inflight != '0);
    we        = beat & (drop == '0) & ~clr_i;
    re        = (count != '0) & rsp_ready_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight <= '0;
      drop     <= '0;
      err      <= 1'b0;
    end else begin
      if (ack_o && !beat)      inflight <= inflight + CNT_W'(1);
      else if (beat && !ack_o) inflight <= inflight - CNT_W'(1);
      // Everything still outstanding after this cycle's beat belongs to killed accesses.
      if (clr_i)                    drop <= inflight - CNT_W'(beat);
      else if (beat && drop != '0)  drop <= drop - CNT_W'(1);
      if (mem_rvalid_i && inflight == '0) err <= 1'b1;
    end
  end

  pu_riscv_memrsp_fifo #(
    .DEPTH (DEPTH),
    .DBITS (DBITS),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .we_i    (we),
    .d_i     (mem_q_i),
    .re_i    (re),
    .q_o     (rsp_q_o),
    .count_o (count)
  );

  assign rsp_valid_o = (count != '0);
  assign empty_o     = (inflight == '0) && (count == '0);
  assign full_o      = ~credit;
  assign err_o       = err;

endmodule

// File: tb/tb_pu_riscv_memrsp.sv
// Bench for pu_riscv_memrsp: directed scenarios then random traffic, each cycle
// checked against a queue-based model of outstanding requests and queued data.
module tb_pu_riscv_memrsp;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned DBITS = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr, ena, req, gnt, rvalid, ready;
  logic [DBITS-1:0] d_in, mem_q;
  logic             ack, mem_req, rsp_valid, empty, full, err;
  logic [DBITS-1:0] mem_d, rsp_q;

  int errors = 0;
  int checks = 0;

  // Model: one entry per outstanding request (1 = killed by a flush), plus queued data.
  bit               pend[$];
  logic [DBITS-1:0] rq[$];
  logic [DBITS-1:0] last_q;
  bit               err_m;

  always #5 clk = ~clk;

  pu_riscv_memrsp #(.DEPTH(DEPTH), .DBITS(DBITS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .ena_i(ena), .req_i(req), .d_i(d_in),
    .ack_o(ack), .mem_req_o(mem_req), .mem_d_o(mem_d), .mem_gnt_i(gnt),
    .mem_rvalid_i(rvalid), .mem_q_i(mem_q), .rsp_valid_o(rsp_valid), .rsp_q_o(rsp_q),
    .rsp_ready_i(ready), .empty_o(empty), .full_o(full), .err_o(err)
  );

  task automatic chk(input string tag, input logic [DBITS-1:0] obs, input logic [DBITS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check all outputs mid-cycle, advance the model.
  task automatic cyc(input bit r, input logic [DBITS-1:0] d, input bit g, input bit rv,
                     input logic [DBITS-1:0] q, input bit rdy, input bit cl, input bit en);
    bit cr, mr, ak, k;
    req = r; d_in = d; gnt = g; rvalid = rv; mem_q = q; ready = rdy; clr = cl; ena = en;
    @(negedge clk);
    cr = (pend.size() + rq.size()) < DEPTH;
    mr = r & en & ~cl & cr;
    ak = mr & g;
    chk("mem_req", {63'd0, mem_req}, {63'd0, mr});
    chk("ack", {63'd0, ack}, {63'd0, ak});
    chk("mem_d", mem_d, d);
    chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, rq.size() != 0});
    chk("rsp_q", rsp_q, (rq.size() != 0) ? rq[0] : last_q);
    chk("empty", {63'd0, empty}, {63'd0, pend.size() == 0 && rq.size() == 0});
    chk("full", {63'd0, full}, {63'd0, !cr});
    chk("err", {63'd0, err}, {63'd0, err_m});
    if (rq.size() != 0) last_q = rq[0];
    if (rq.size() != 0 && rdy) void'(rq.pop_front());
    if (rv) begin
      if (pend.size() == 0) err_m = 1'b1;
      else begin
        k = pend.pop_front();
        if (!k && !cl) rq.push_back(q);
      end
    end
    if (cl) begin
      rq.delete();
      foreach (pend[i]) pend[i] = 1'b1;
    end
    if (ak) pend.push_back(1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    cyc(0, '0, 0, 0, '0, rdy, 0, 1);
  endtask

  task automatic async_reset();
    req = 0; rvalid = 0; clr = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("arst_q", rsp_q, 64'd0);
    chk("arst_empty", {63'd0, empty}, 64'd1);
    chk("arst_full", {63'd0, full}, 64'd0);
    chk("arst_err", {63'd0, err}, 64'd0);
    chk("arst_mem_req", {63'd0, mem_req}, 64'd0);
    pend.delete(); rq.delete(); last_q = '0; err_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit r, g, rv, rdy, cl, en;
    logic [DBITS-1:0] d, q;
    rst_n = 1'b0; clr = 0; ena = 0; req = 0; gnt = 0; rvalid = 0; ready = 0;
    d_in = '0; mem_q = '0; last_q = '0; err_m = 1'b0;
    #12;
    chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_q", rsp_q, 64'd0);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_full", {63'd0, full}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_ack", {63'd0, ack}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single read
    cyc(1, 64'h1000, 1, 0, '0, 0, 0, 1);
    idle(0);
    cyc(0, '0, 0, 1, 64'hDEAD_BEEF, 0, 0, 1);
    chk("single_valid", {63'd0, rsp_valid}, 64'd1);
    chk("single_q", rsp_q, 64'hDEAD_BEEF);
    idle(1);
    chk("single_empty", {63'd0, empty}, 64'd1);

    // credit stall
    cyc(1, 64'h2001, 1, 0, '0, 0, 0, 1);
    cyc(1, 64'h2002, 1, 0, '0, 0, 0, 1);
    chk("stall_full", {63'd0, full}, 64'd1);
    cyc(1, 64'h2003, 1, 0, '0, 0, 0, 1);
    chk("stall_noreq", {63'd0, mem_req}, 64'd0);
    cyc(0, '0, 0, 1, 64'hA, 0, 0, 1);
    cyc(0, '0, 0, 1, 64'hB, 0, 0, 1);
    chk("stall_full2", {63'd0, full}, 64'd1);
    chk("stall_headA", rsp_q, 64'hA);
    idle(1);
    chk("stall_headB", rsp_q, 64'hB);
    cyc(1, 64'h2004, 1, 0, '0, 0, 0, 1);
    cyc(0, '0, 0, 1, 64'h5, 1, 0, 1);
    idle(1);
    idle(0);

    // back-to-back ordering
    cyc(1, 64'h3001, 1, 0, '0, 1, 0, 1);
    cyc(1, 64'h3002, 1, 1, 64'h11, 1, 0, 1);
    chk("order_11", rsp_q, 64'h11);
    cyc(0, '0, 0, 1, 64'h22, 1, 0, 1);
    chk("order_22", rsp_q, 64'h22);
    idle(1);
    idle(1);

    // flush with two in flight
    cyc(1, 64'h4001, 1, 0, '0, 0, 0, 1);
    cyc(1, 64'h4002, 1, 0, '0, 0, 0, 1);
    cyc(1, 64'h4003, 1, 0, '0, 0, 1, 1);
    cyc(0, '0, 0, 1, 64'hAA, 0, 0, 1);
    cyc(0, '0, 0, 1, 64'hBB, 0, 0, 1);
    chk("flush_novalid", {63'd0, rsp_valid}, 64'd0);
    chk("flush_empty", {63'd0, empty}, 64'd1);
    cyc(1, 64'h4004, 1, 0, '0, 0, 0, 1);
    cyc(0, '0, 0, 1, 64'hCC, 0, 0, 1);
    chk("flush_cc", rsp_q, 64'hCC);
    idle(1);

    // flush coinciding with a beat
    cyc(1, 64'h5001, 1, 0, '0, 0, 0, 1);
    cyc(1, 64'h5002, 1, 0, '0, 0, 0, 1);
    cyc(0, '0, 0, 1, 64'h01, 0, 1, 1);
    cyc(0, '0, 0, 1, 64'h02, 0, 0, 1);
    chk("flushb_novalid", {63'd0, rsp_valid}, 64'd0);
    cyc(1, 64'h5003, 1, 0, '0, 0, 0, 1);
    cyc(0, '0, 0, 1, 64'h03, 0, 0, 1);
    chk("flushb_03", rsp_q, 64'h03);
    idle(1);

    // ena_i low blocks acceptance but responses still flow
    cyc(1, 64'h6001, 1, 0, '0, 0, 0, 1);
    cyc(1, 64'h6002, 1, 1, 64'h66, 0, 0, 0);
    chk("ena_capture", rsp_q, 64'h66);
    idle(1);

    // protocol error, then asynchronous reset mid-transaction
    cyc(0, '0, 0, 1, 64'h99, 0, 0, 1);
    chk("err_set", {63'd0, err}, 64'd1);
    chk("err_novalid", {63'd0, rsp_valid}, 64'd0);
    idle(0);
    chk("err_sticky", {63'd0, err}, 64'd1);
    cyc(1, 64'h7001, 1, 0, '0, 0, 0, 1);
    cyc(0, '0, 0, 1, 64'h77, 0, 0, 1);
    async_reset();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(0, 1) == 1);
      d   = {$urandom, $urandom};
      g   = ($urandom_range(0, 3) != 0);
      rv  = (pend.size() != 0) && ($urandom_range(0, 2) == 0);
      q   = {$urandom, $urandom};
      rdy = ($urandom_range(0, 2) != 0);
      cl  = ($urandom_range(0, 24) == 0);
      en  = ($urandom_range(0, 9) != 0);
      cyc(r, d, g, rv, q, rdy, cl, en);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
